// File: rtl/non_fast_pattern_hit_extractor_pkg.sv
// ---------------------------------------------------------------------------
// non_fast_pattern_hit_extractor_pkg
//
// Purpose : shared widths, record types, FSM state encoding and the
//           lowest-set-bit encoder used by the non-fast-pattern hit
//           extractor and its beat FIFO.
//
// Contents:
//   NFP_DWIDTH / NFP_NBUCKET / NFP_OFF_W   vector, bucket and offset widths
//   nfp_event_t                            one serialised output event
//   nfp_entry_t                            one buffered beat {hit, base, eop}
//   nfp_state_e                            scan FSM states
//   nfp_lowest_set()                       index of lowest set bit
// ---------------------------------------------------------------------------
package non_fast_pattern_hit_extractor_pkg;

  localparam int NFP_DWIDTH  = 128;
  localparam int NFP_NBUCKET = 8;
  localparam int NFP_OFF_W   = 16;

  localparam int NFP_BKT_W  = $clog2(NFP_NBUCKET);
  localparam int NFP_IDX_W  = $clog2(NFP_DWIDTH);
  localparam int NFP_LANE_W = NFP_IDX_W - NFP_BKT_W;
  localparam int NFP_LANES  = NFP_DWIDTH / NFP_NBUCKET;

  // Base advances by one beat's worth of bytes and pins at the last beat
  // start that still fits, so base + lane never wraps the offset field.
  localparam logic [NFP_OFF_W-1:0] NFP_BASE_STEP = NFP_OFF_W'(NFP_LANES);
  localparam logic [NFP_OFF_W-1:0] NFP_BASE_MAX  = NFP_OFF_W'((2 ** NFP_OFF_W) - NFP_LANES);

  typedef struct packed {
    logic [NFP_OFF_W-1:0] offset;
    logic [NFP_BKT_W-1:0] bucket;
    logic                 eop;
  } nfp_event_t;

  typedef struct packed {
    logic [NFP_DWIDTH-1:0] hit;   // 1 = hit (inverted shift-or vector)
    logic [NFP_OFF_W-1:0]  base;  // packet-relative offset of byte lane 0
    logic                  eop;
  } nfp_entry_t;

  localparam int NFP_ENTRY_W = $bits(nfp_entry_t);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_EOP  = 2'd2
  } nfp_state_e;

  // Index of the lowest set bit; 0 when the vector is empty (callers gate
  // on |vec). Scanning downward lets the lowest index overwrite last.
  function automatic logic [NFP_IDX_W-1:0] nfp_lowest_set(input logic [NFP_DWIDTH-1:0] vec);
    logic [NFP_IDX_W-1:0] idx;
    idx = '0;
    for (int i = NFP_DWIDTH - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = NFP_IDX_W'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/nfp_hit_fifo.sv
// ---------------------------------------------------------------------------
// nfp_hit_fifo
//
// Purpose : show-ahead synchronous FIFO for buffered beats. The head entry
//           is visible on o_rd_data whenever o_empty is low; i_rd_en pops it.
//           A write and a read in the same cycle are accepted even when full.
//
// Ports   :
//   clk, rst          clock, synchronous active-high reset (flushes)
//   i_wr_en/i_wr_data push one entry (ignored when full without a read)
//   i_rd_en           pop head entry (ignored when empty)
//   o_rd_data         head entry
//   o_empty, o_full   occupancy flags
//   o_almost_full     occupancy >= depth - AF_MARGIN
// ---------------------------------------------------------------------------
module nfp_hit_fifo
  import non_fast_pattern_hit_extractor_pkg::*;
#(
  parameter int WIDTH     = NFP_ENTRY_W,
  parameter int AWIDTH    = 5,
  parameter int AF_MARGIN = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_empty,
  output logic             o_full,
  output logic             o_almost_full
);

  localparam int DEPTH = 1 << AWIDTH;
  localparam logic [AWIDTH:0] AF_LEVEL = (AWIDTH + 1)'(DEPTH - AF_MARGIN);
  localparam logic [AWIDTH:0] FULL_LEVEL = (AWIDTH + 1)'(DEPTH);

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [AWIDTH-1:0] r_wr_ptr;
  logic [AWIDTH-1:0] r_rd_ptr;
  logic [AWIDTH:0]   r_count;

  logic w_do_wr;
  logic w_do_rd;

  assign o_empty       = (r_count == '0);
  assign o_full        = (r_count == FULL_LEVEL);
  assign o_almost_full = (r_count >= AF_LEVEL);

  assign w_do_rd = i_rd_en && !o_empty;
  // When full, a same-cycle pop frees the slot the write lands in.
  assign w_do_wr = i_wr_en && (!o_full || w_do_rd);

  // Show-ahead needs the head visible without a read cycle, so the storage
  // is read combinationally (distributed RAM).
  assign o_rd_data = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_do_wr) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_rd) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_do_wr && !w_do_rd) begin
        r_count <= r_count + 1'b1;
      end else if (w_do_rd && !w_do_wr) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/non_fast_pattern_hit_extractor.sv
// ---------------------------------------------------------------------------
// non_fast_pattern_hit_extractor
//
// Purpose : takes per-beat shift-or state vectors (0 bit = bucket pattern
//           ended at that byte), buffers them, and serialises every hit into
//           one event per cycle carrying a packet-relative byte offset and a
//           bucket id, followed by an end-of-packet marker event.
//
// Ports   :
//   clk, rst        clock, synchronous active-high reset
//   in_data         shift-or vector, bit 8*i+b = bucket b of byte i, 0 = hit
//   in_valid        beat valid (no backpressure)
//   in_sop/in_eop   first / last beat of packet
//   in_almost_full  beat FIFO occupancy >= depth-4
//   out_valid       event valid, held with its data until out_ready
//   out_ready       downstream accept
//   out_offset      byte offset of hit within packet (0 on marker)
//   out_bucket      bucket id (0 on marker)
//   out_eop         1 = end-of-packet marker
//   drop_cnt        beats dropped on FIFO full (saturating)
// ---------------------------------------------------------------------------
module non_fast_pattern_hit_extractor
  import non_fast_pattern_hit_extractor_pkg::*;
#(
  parameter int DWIDTH      = NFP_DWIDTH,
  parameter int NBUCKET     = NFP_NBUCKET,
  parameter int FIFO_AWIDTH = 5,
  parameter int OFF_W       = NFP_OFF_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DWIDTH-1:0]          in_data,
  input  logic                       in_valid,
  input  logic                       in_sop,
  input  logic                       in_eop,
  output logic                       in_almost_full,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OFF_W-1:0]           out_offset,
  output logic [$clog2(NBUCKET)-1:0] out_bucket,
  output logic                       out_eop,
  output logic [31:0]                drop_cnt
);

  localparam logic [NFP_DWIDTH-1:0] ONE_HOT0 = NFP_DWIDTH'(1);

  // ------------------------------------------------------------------
  // Ingress: base tracking and drop accounting
  // ------------------------------------------------------------------
  logic [NFP_OFF_W-1:0] r_next_base;
  logic [31:0]          r_drop_cnt;
  logic [NFP_OFF_W-1:0] w_beat_base;
  logic [NFP_OFF_W-1:0] w_base_inc;
  nfp_entry_t           w_wr_entry;
  nfp_entry_t           w_rd_entry;
  logic                 w_wr_en;
  logic                 w_rd_en;
  logic                 w_empty;
  logic                 w_full;
  logic                 w_almost_full;

  assign w_beat_base = in_sop ? '0 : r_next_base;
  assign w_base_inc  = (w_beat_base >= NFP_BASE_MAX) ? NFP_BASE_MAX
                                                     : (w_beat_base + NFP_BASE_STEP);

  always_comb begin
    w_wr_entry      = '0;
    w_wr_entry.hit  = ~in_data;
    w_wr_entry.base = w_beat_base;
    w_wr_entry.eop  = in_eop;
  end

  // A beat is accepted if there is room now or a pop this cycle makes room.
  assign w_wr_en = in_valid && (!w_full || w_rd_en);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_next_base <= '0;
      r_drop_cnt  <= '0;
    end else begin
      // Base advances for dropped beats too, keeping later offsets exact.
      if (in_valid) begin
        r_next_base <= w_base_inc;
      end
      if (in_valid && !w_wr_en && (r_drop_cnt != 32'hFFFF_FFFF)) begin
        r_drop_cnt <= r_drop_cnt + 32'd1;
      end
    end
  end

  nfp_hit_fifo #(
    .WIDTH     (NFP_ENTRY_W),
    .AWIDTH    (FIFO_AWIDTH),
    .AF_MARGIN (4)
  ) u_fifo (
    .clk           (clk),
    .rst           (rst),
    .i_wr_en       (w_wr_en),
    .i_wr_data     (w_wr_entry),
    .i_rd_en       (w_rd_en),
    .o_rd_data     (w_rd_entry),
    .o_empty       (w_empty),
    .o_full        (w_full),
    .o_almost_full (w_almost_full)
  );

  // ------------------------------------------------------------------
  // Scan FSM and registered output slot
  // ------------------------------------------------------------------
  nfp_state_e            r_state;
  logic [NFP_DWIDTH-1:0] r_scan_hit;
  logic [NFP_OFF_W-1:0]  r_scan_base;
  logic                  r_scan_eop;
  nfp_event_t            r_out;
  logic                  r_out_valid;

  logic                  w_slot_free;
  logic                  w_scan_any;
  logic [NFP_IDX_W-1:0]  w_idx;
  logic [NFP_DWIDTH-1:0] w_scan_rem;
  logic [NFP_OFF_W-1:0]  w_hit_off;
  logic                  w_emit_hit;
  logic                  w_scan_done;
  logic                  w_emit_eop;

  assign w_slot_free = !r_out_valid || out_ready;
  assign w_scan_any  = |r_scan_hit;
  assign w_idx       = nfp_lowest_set(r_scan_hit);
  assign w_scan_rem  = r_scan_hit & ~(ONE_HOT0 << w_idx);
  assign w_hit_off   = r_scan_base + {{(NFP_OFF_W - NFP_LANE_W){1'b0}}, w_idx[NFP_IDX_W-1:NFP_BKT_W]};

  assign w_emit_hit  = (r_state == ST_SCAN) && w_scan_any && w_slot_free;
  // The beat is finished either when it had nothing left, or when the hit
  // being emitted now is its last one. Acting on the latter in the same
  // cycle lets the next beat's hits (or the marker) follow back to back.
  assign w_scan_done = (r_state == ST_SCAN) &&
                       (!w_scan_any || (w_slot_free && !(|w_scan_rem)));
  assign w_emit_eop  = (r_state == ST_EOP) && w_slot_free;

  assign w_rd_en = !w_empty &&
                   ((r_state == ST_IDLE) || (w_scan_done && !r_scan_eop) || w_emit_eop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_scan_hit  <= '0;
      r_scan_base <= '0;
      r_scan_eop  <= 1'b0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      // Accepted event leaves the slot unless refilled below.
      if (out_ready) begin
        r_out_valid <= 1'b0;
      end

      if (w_emit_hit) begin
        r_out_valid  <= 1'b1;
        r_out.offset <= w_hit_off;
        r_out.bucket <= w_idx[NFP_BKT_W-1:0];
        r_out.eop    <= 1'b0;
        r_scan_hit   <= w_scan_rem;
      end

      if (w_emit_eop) begin
        r_out_valid  <= 1'b1;
        r_out.offset <= '0;
        r_out.bucket <= '0;
        r_out.eop    <= 1'b1;
      end

      // A pop replaces the scan register outright (later assignment wins).
      if (w_rd_en) begin
        r_scan_hit  <= w_rd_entry.hit;
        r_scan_base <= w_rd_entry.base;
        r_scan_eop  <= w_rd_entry.eop;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_rd_en) begin
            r_state <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (w_scan_done) begin
            if (r_scan_eop) begin
              r_state <= ST_EOP;
            end else if (w_rd_en) begin
              r_state <= ST_SCAN;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        ST_EOP: begin
          if (w_emit_eop) begin
            r_state <= w_rd_en ? ST_SCAN : ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign out_valid      = r_out_valid;
  assign out_offset     = r_out.offset;
  assign out_bucket     = r_out.bucket;
  assign out_eop        = r_out.eop;
  assign in_almost_full = w_almost_full;
  assign drop_cnt       = r_drop_cnt;

endmodule

// File: tb/tb_non_fast_pattern_hit_extractor.sv
// ---------------------------------------------------------------------------
// tb_non_fast_pattern_hit_extractor
//
// Directed bench: expected events are queued when beats are driven and
// compared as the DUT hands them over; held data under backpressure and
// cycle-level timing are checked alongside.
// ---------------------------------------------------------------------------
module tb_non_fast_pattern_hit_extractor;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] in_data;
  logic         in_valid;
  logic         in_sop;
  logic         in_eop;
  logic         in_almost_full;
  logic         out_valid;
  logic         out_ready;
  logic [15:0]  out_offset;
  logic [2:0]   out_bucket;
  logic         out_eop;
  logic [31:0]  drop_cnt;

  non_fast_pattern_hit_extractor dut (
    .clk            (clk),
    .rst            (rst),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_sop         (in_sop),
    .in_eop         (in_eop),
    .in_almost_full (in_almost_full),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_offset     (out_offset),
    .out_bucket     (out_bucket),
    .out_eop        (out_eop),
    .drop_cnt       (drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] off;
    logic [2:0]  bkt;
    logic        eop;
  } ev_t;

  ev_t exp_q[$];
  int  n_vec = 0;
  int  n_err = 0;
  int  cyc = 0;
  int  last_acc = -1;
  bit  chk_consec = 1'b0;
  bit  prev_stall = 1'b0;
  logic [31:0] prev_data = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void push_ev(input logic [15:0] o, input logic [2:0] b, input logic e);
    ev_t t;
    t.off = o;
    t.bkt = b;
    t.eop = e;
    exp_q.push_back(t);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [127:0] d, input logic sop, input logic eop);
    in_data  = d;
    in_sop   = sop;
    in_eop   = eop;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
    in_data  = '1;
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: inputs change just after posedge, so at negedge out_ready and
  // out_valid already hold the values the next posedge will act on.
  always @(negedge clk) begin
    ev_t e;
    cyc++;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", {12'b0, out_offset, out_bucket, out_eop}, prev_data);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_event", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          check("event", {12'b0, out_offset, out_bucket, out_eop}, {12'b0, e.off, e.bkt, e.eop});
          $display("event off=%0h bkt=%0d eop=%0b cyc=%0d", out_offset, out_bucket, out_eop, cyc);
        end
        if (chk_consec) begin
          if (last_acc >= 0) begin
            check("consecutive", 32'(cyc), 32'(last_acc + 1));
          end
          last_acc = cyc;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = {12'b0, out_offset, out_bucket, out_eop};
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_base;
    rst       = 1'b1;
    in_data   = '1;
    in_valid  = 1'b0;
    in_sop    = 1'b0;
    in_eop    = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset state
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_eop", 32'(out_eop), 32'd0);
    check("rst_out_offset", 32'(out_offset), 32'd0);
    check("rst_out_bucket", 32'(out_bucket), 32'd0);
    check("rst_almost_full", 32'(in_almost_full), 32'd0);
    check("rst_drop_cnt", drop_cnt, 32'd0);

    // 1: single beat, hit at bit 19 -> byte 2 bucket 3, then marker; latency T+3
    push_ev(16'd2, 3'd3, 1'b0);
    push_ev(16'd0, 3'd0, 1'b1);
    send_beat(~(128'h1 << 19), 1'b1, 1'b1);
    check("lat_t1", 32'(out_valid), 32'd0);
    tick();
    check("lat_t2", 32'(out_valid), 32'd0);
    tick();
    check("lat_t3", 32'(out_valid), 32'd1);
    drain("single", 20);

    // 2: two-beat packet, events on consecutive cycles
    chk_consec = 1'b1;
    last_acc   = -1;
    push_ev(16'd0, 3'd0, 1'b0);
    push_ev(16'd15, 3'd7, 1'b0);
    push_ev(16'd17, 3'd0, 1'b0);
    push_ev(16'd0, 3'd0, 1'b1);
    send_beat(~(128'h1 | (128'h1 << 127)), 1'b1, 1'b0);
    send_beat(~(128'h1 << 8), 1'b0, 1'b1);
    drain("two_beat", 20);
    chk_consec = 1'b0;
    repeat (3) tick();

    // 3: same packet with out_ready toggling; monitor checks hold while stalled
    out_ready = 1'b0;
    push_ev(16'd0, 3'd0, 1'b0);
    push_ev(16'd15, 3'd7, 1'b0);
    push_ev(16'd17, 3'd0, 1'b0);
    push_ev(16'd0, 3'd0, 1'b1);
    send_beat(~(128'h1 | (128'h1 << 127)), 1'b1, 1'b0);
    send_beat(~(128'h1 << 8), 1'b0, 1'b1);
    for (int c = 0; c < 40 && exp_q.size() != 0; c++) begin
      out_ready = ~out_ready;
      tick();
    end
    check("toggle_drained", 32'(exp_q.size()), 32'd0);
    out_ready = 1'b1;
    repeat (3) tick();

    // 4: stall the output on a 2-hit beat, then 40 zero-hit beats fill the FIFO
    out_ready = 1'b0;
    push_ev(16'd0, 3'd0, 1'b0);
    push_ev(16'd0, 3'd1, 1'b0);
    send_beat(~128'h3, 1'b1, 1'b0);
    repeat (3) tick();
    check("fill_stalled_valid", 32'(out_valid), 32'd1);
    for (int k = 1; k <= 40; k++) begin
      send_beat('1, 1'b0, k == 40);
      if (k == 27) check("af_at_27", 32'(in_almost_full), 32'd0);
      if (k == 28) check("af_at_28", 32'(in_almost_full), 32'd1);
    end
    check("drop_cnt_8", drop_cnt, 32'd8);
    out_ready = 1'b1;
    drain("fill", 20);
    repeat (50) tick();
    check("fill_no_marker", 32'(out_valid), 32'd0);
    check("fill_af_clear", 32'(in_almost_full), 32'd0);

    // 5: reset mid-scan of a 128-hit beat
    for (int j = 0; j < 128; j++) push_ev(16'(j / 8), 3'(j % 8), 1'b0);
    push_ev(16'd0, 3'd0, 1'b1);
    send_beat('0, 1'b1, 1'b1);
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_drop_cnt", drop_cnt, 32'd0);
    repeat (5) tick();
    check("midrst_quiet", 32'(out_valid), 32'd0);
    push_ev(16'd0, 3'd0, 1'b0);
    push_ev(16'd0, 3'd0, 1'b1);
    send_beat(~128'h1, 1'b1, 1'b1);
    drain("post_rst", 20);

    // 6: 4100 zero-hit beats, then a byte-0 hit: base saturates at 0xFFF0
    exp_base = (4100 * 16 > 65520) ? 65520 : 4100 * 16;
    push_ev(16'(exp_base), 3'd0, 1'b0);
    push_ev(16'd0, 3'd0, 1'b1);
    for (int i = 0; i < 4100; i++) send_beat('1, i == 0, 1'b0);
    send_beat(~128'h1, 1'b0, 1'b1);
    drain("saturate", 40);
    check("sat_drop_cnt", drop_cnt, 32'd0);
    repeat (5) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
